// File: rtl/my_sum8_pkg.sv
// rtl/my_sum8_pkg.sv - shared width default and golden-sum helper for my_sum8
package my_sum8_pkg;

  localparam int WIDTH_DEFAULT = 8;

  // Golden {carry, sum} at the default width, computed with plain arithmetic
  function automatic logic [WIDTH_DEFAULT:0] ref_add(
    input logic [WIDTH_DEFAULT-1:0] a,
    input logic [WIDTH_DEFAULT-1:0] b,
    input logic                     ci
  );
    logic [WIDTH_DEFAULT:0] r;
    r = {1'b0, a} + {1'b0, b} + {{WIDTH_DEFAULT{1'b0}}, ci};
    return r;
  endfunction

endpackage

// File: rtl/my_sum8_fa.sv
// rtl/my_sum8_fa.sv - one-bit full adder cell of the ripple chain
module my_sum8_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic p;

  // Propagate term is shared between the sum and the carry
  assign p  = a ^ b;
  assign s  = p ^ cin;
  assign co = (a & b) | (cin & p);

endmodule

// File: rtl/my_sum8.sv
// rtl/my_sum8.sv - registered ripple-carry adder with carry-in and carry-out
module my_sum8
  import my_sum8_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             ci,
  input  logic             in_vld,
  output logic [WIDTH-1:0] res,
  output logic             co,
  output logic             out_vld
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_w;

  logic [WIDTH-1:0] res_d, res_q;
  logic             co_d, co_q;
  logic             out_vld_d, out_vld_q;

  assign carry[0] = ci;

  // Carry ripples combinationally from the pins straight into the output register
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    my_sum8_fa u_fa (
      .a   (ain[i]),
      .b   (bin[i]),
      .cin (carry[i]),
      .s   (sum_w[i]),
      .co  (carry[i+1])
    );
  end

  // Capture only on valid cycles so junk operands never reach res/co
  always_comb begin
    res_d     = res_q;
    co_d      = co_q;
    out_vld_d = 1'b0;
    if (in_vld) begin
      res_d     = sum_w;
      co_d      = carry[WIDTH];
      out_vld_d = 1'b1;
    end
  end

  // Output stage; reset discards any pending result at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q     <= '0;
      co_q      <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      res_q     <= res_d;
      co_q      <= co_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign res     = res_q;
  assign co      = co_q;
  assign out_vld = out_vld_q;

endmodule

// File: tb/tb_my_sum8.sv
// tb/tb_my_sum8.sv - self-checking bench for my_sum8
module tb_my_sum8;
  import my_sum8_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] ain = '0;
  logic [W-1:0] bin = '0;
  logic         ci = 1'b0;
  logic         in_vld = 1'b0;
  logic [W-1:0] res;
  logic         co;
  logic         out_vld;

  int checks = 0;
  int errors = 0;

  // Model state: what the outputs must show after the most recent edge
  logic [W-1:0] m_res = '0;
  logic         m_co  = 1'b0;
  logic         m_vld = 1'b0;
  logic [W:0]   gold;

  my_sum8 #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .ain     (ain),
    .bin     (bin),
    .ci      (ci),
    .in_vld  (in_vld),
    .res     (res),
    .co      (co),
    .out_vld (out_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sum on a valid edge, hold otherwise, zero on reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_res <= '0;
      m_co  <= 1'b0;
      m_vld <= 1'b0;
    end else begin
      m_vld <= in_vld;
      if (in_vld) begin
        gold = ref_add(ain, bin, ci);
        m_res <= gold[W-1:0];
        m_co  <= gold[W];
      end
    end
  end

  // Continuous compare on the falling edge, away from the active edge
  always @(negedge clk) begin
    chk("model_res", {56'd0, res}, {56'd0, m_res});
    chk("model_co", {63'd0, co}, {63'd0, m_co});
    chk("model_vld", {63'd0, out_vld}, {63'd0, m_vld});
  end

  // Present one valid operand set, then check the registered result one cycle later
  task automatic add_once(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] exp_res, input logic exp_co, input string name);
    @(posedge clk); #1;
    ain = a; bin = b; ci = c; in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    chk({name, "_res"}, {56'd0, res}, {56'd0, exp_res});
    chk({name, "_co"}, {63'd0, co}, {63'd0, exp_co});
    chk({name, "_vld"}, {63'd0, out_vld}, 64'd1);
  endtask

  logic [W-1:0] ta [8] = '{8'd1, 8'd128, 8'd1, 8'd128, 8'd255, 8'd255, 8'd128, 8'd0};
  logic [W-1:0] tb [8] = '{8'd2, 8'd2, 8'd64, 8'd64, 8'd1, 8'd255, 8'd128, 8'd0};
  logic         tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [W-1:0] tr0 [4] = '{8'd3, 8'd130, 8'd65, 8'd192};
  logic [W-1:0] tr1 [4] = '{8'd4, 8'd131, 8'd66, 8'd193};
  logic [W-1:0] wr  [4] = '{8'd0, 8'd255, 8'd0, 8'd0};
  logic         wco [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [W:0]   pin;

  initial begin
    // Pin the golden helper itself with hand-computed values
    pin = ref_add(8'd255, 8'd255, 1'b1);
    chk("ref_255_255_1", {55'd0, pin}, 64'd511);
    pin = ref_add(8'd128, 8'd64, 1'b1);
    chk("ref_128_64_1", {55'd0, pin}, 64'd193);

    // Reset held with random inputs
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      ain = W'($urandom); bin = W'($urandom); ci = 1'($urandom); in_vld = 1'($urandom);
    end
    chk("rst_res", {56'd0, res}, 64'd0);
    chk("rst_co", {63'd0, co}, 64'd0);
    chk("rst_vld", {63'd0, out_vld}, 64'd0);
    in_vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_res", {56'd0, res}, 64'd0);
    chk("post_rst_vld", {63'd0, out_vld}, 64'd0);

    // Basic sums, ci=0 and ci=1
    for (int i = 0; i < 4; i++) add_once(ta[i], tb[i], 1'b0, tr0[i], 1'b0, $sformatf("basic0_%0d", i));
    for (int i = 0; i < 4; i++) add_once(ta[i], tb[i], 1'b1, tr1[i], 1'b0, $sformatf("basic1_%0d", i));

    // Wrap and carry
    for (int i = 0; i < 4; i++) add_once(ta[i+4], tb[i+4], tc[i], wr[i], wco[i], $sformatf("wrap_%0d", i));

    // Hold and single-cycle out_vld
    add_once(8'd1, 8'd2, 1'b0, 8'd3, 1'b0, "pulse");
    ain = 8'd200; bin = 8'd100; ci = 1'b1;
    @(posedge clk); #1;
    chk("hold_res", {56'd0, res}, 64'd3);
    chk("hold_co", {63'd0, co}, 64'd0);
    chk("hold_vld", {63'd0, out_vld}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("hold2_res", {56'd0, res}, 64'd3);

    // Asynchronous reset mid-stream: clears before the next edge
    add_once(8'd200, 8'd100, 1'b1, 8'd45, 1'b1, "pre_arst");
    in_vld = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_res", {56'd0, res}, 64'd0);
    chk("arst_co", {63'd0, co}, 64'd0);
    chk("arst_vld", {63'd0, out_vld}, 64'd0);
    in_vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Random traffic, checked continuously against the model
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      ain = W'($urandom); bin = W'($urandom); ci = 1'($urandom); in_vld = 1'($urandom);
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
